// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: gate/clear/latch sequencer for a BCD frequency counter.
// Optional FREQ_AUTORANGE_EN: continuous-mode range step-down on overflow.
module freq_meas_ctrl #(
    parameter int GATE_BASE   = 100000,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sig_in,
    input  logic       start,
    input  logic       cont,
    input  logic [1:0] gate_sel,
    input  logic       carry_in,
    output logic       cnt_pulse,
    output logic       cnt_clr,
    output logic       latch,
    output logic       gate,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic [1:0] gate_sel_q
);
    localparam int CW = $clog2(GATE_BASE * 1000 + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] LEN0 = CW'(GATE_BASE - 1);
    localparam logic [CW-1:0] LEN1 = CW'(GATE_BASE * 10 - 1);
    localparam logic [CW-1:0] LEN2 = CW'(GATE_BASE * 100 - 1);
    localparam logic [CW-1:0] LEN3 = CW'(GATE_BASE * 1000 - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_GATE  = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hold;
    logic          r_ovf;
    logic [1:0]    r_selq;
    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic          w_edge;
    logic          w_gate;
    logic [1:0]    w_sel_next;
    logic [CW-1:0] w_len;

    // Two-flop synchroniser plus delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s3;

`ifdef FREQ_AUTORANGE_EN
    logic       r_auto_vld;
    logic [1:0] r_auto_sel;

    // Step the range down after an overflowing continuous measurement
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_auto_vld <= 1'b0;
            r_auto_sel <= 2'd0;
        end else if (!cont) begin
            r_auto_vld <= 1'b0;
        end else if (r_state == S_DONE && r_ovf) begin
            r_auto_vld <= 1'b1;
            r_auto_sel <= (r_selq != 2'd0) ? r_selq - 2'd1 : 2'd0;
        end
    end

    assign w_sel_next = r_auto_vld ? r_auto_sel : gate_sel;
`else
    assign w_sel_next = gate_sel;
`endif

    // Gate counter preload (length minus one) for the range being captured
    always_comb begin
        w_len = LEN0;
        case (w_sel_next)
            2'd0: w_len = LEN0;
            2'd1: w_len = LEN1;
            2'd2: w_len = LEN2;
            2'd3: w_len = LEN3;
        endcase
    end

    // Measurement sequencer: clear, gate, latch, done, hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_ovf   <= 1'b0;
            r_selq  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start | cont) r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_selq  <= w_sel_next;
                    r_ovf   <= 1'b0;
                    r_cnt   <= w_len;
                    r_state <= S_GATE;
                end
                S_GATE: begin
                    if (carry_in) r_ovf <= 1'b1;
                    if (r_cnt == '0) r_state <= S_LATCH;
                    else r_cnt <= r_cnt - 1'b1;
                end
                S_LATCH: begin
                    if (carry_in) r_ovf <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_hold  <= HW'(HOLD_CYCLES - 1);
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold == '0) r_state <= cont ? S_CLEAR : S_IDLE;
                    else r_hold <= r_hold - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_gate     = (r_state == S_GATE);
    assign gate       = w_gate;
    assign cnt_pulse  = w_edge & w_gate;
    assign cnt_clr    = (r_state == S_CLEAR);
    assign latch      = (r_state == S_LATCH);
    assign done       = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_ovf;
    assign gate_sel_q = r_selq;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: scoreboard bench for freq_meas_ctrl.
// Runs at GATE_BASE=10, HOLD_CYCLES=4.
module tb_freq_meas_ctrl;
    localparam int GB = 10;
    localparam int HC = 4;

    typedef struct packed {
        int         len;
        int         pulses;
        logic       ovf;
        logic [1:0] selq;
    } res_t;

    typedef struct packed {
        int         len;
        int         pmin;
        int         pmax;
        logic       ovf;
        logic [1:0] selq;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sig_in = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [1:0] gate_sel = 2'd0;
    logic       carry_in = 1'b0;
    logic       cnt_pulse;
    logic       cnt_clr;
    logic       latch;
    logic       gate;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [1:0] gate_sel_q;

    int checks = 0;
    int errors = 0;
    int half = 0;
    int ph = 0;
    int cyc = 0;
    int m_len = 0;
    int m_pulses = 0;
    int clr_cnt = 0;
    int latch_cnt = 0;
    int done_cnt = 0;
    int excl = 0;
    int last_clr = 0;
    int clr_period = 0;

    res_t res_q[$];
    exp_t exp_q[$];

    freq_meas_ctrl #(.GATE_BASE(GB), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
        .cont(cont), .gate_sel(gate_sel), .carry_in(carry_in),
        .cnt_pulse(cnt_pulse), .cnt_clr(cnt_clr), .latch(latch),
        .gate(gate), .busy(busy), .done(done), .overflow(overflow),
        .gate_sel_q(gate_sel_q)
    );

    always #5 clk = ~clk;

    // signal under test: toggles every 'half' cycles (0 = frozen)
    always @(negedge clk) begin
        if (half != 0) begin
            ph++;
            if (ph >= half) begin
                ph = 0;
                sig_in = ~sig_in;
            end
        end
    end

    // monitor: measures each window and pushes a result at done
    always @(negedge clk) begin
        res_t r;
        cyc++;
        if (cnt_clr === 1'b1) begin
            m_len = 0;
            m_pulses = 0;
            clr_cnt++;
            clr_period = cyc - last_clr;
            last_clr = cyc;
        end
        if (gate === 1'b1) m_len++;
        if (cnt_pulse === 1'b1) m_pulses++;
        if (latch === 1'b1) latch_cnt++;
        if (int'(cnt_clr === 1'b1) + int'(latch === 1'b1) + int'(gate === 1'b1) > 1) excl++;
        if (done === 1'b1) begin
            done_cnt++;
            r.len = m_len;
            r.pulses = m_pulses;
            r.ovf = overflow;
            r.selq = gate_sel_q;
            res_q.push_back(r);
        end
    end

    function automatic int glen(input int sel);
        int l = GB;
        for (int i = 0; i < sel; i++) l = l * 10;
        return l;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // which: 0=done 1=gate 2=latch 3=cnt_clr
    task automatic wait_for(input int which, input int max, input string nm);
        int n = 0;
        logic s;
        forever begin
            case (which)
                0: s = done;
                1: s = gate;
                2: s = latch;
                default: s = cnt_clr;
            endcase
            if (s === 1'b1 || n >= max) break;
            tick(1);
            n++;
        end
        if (s !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles (signal %0d)", nm, max, which);
        end
    endtask

    task automatic push_exp(input int sel, input int pmin, input int pmax, input logic ovf);
        exp_t e;
        e.len = glen(sel);
        e.pmin = pmin;
        e.pmax = pmax;
        e.ovf = ovf;
        e.selq = 2'(sel);
        exp_q.push_back(e);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        half = 1;
        repeat (3) begin
            tick(1);
            checks++;
            if ({cnt_pulse, cnt_clr, latch, gate, busy, done, overflow, gate_sel_q} !== 9'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b required 000000000",
                         {cnt_pulse, cnt_clr, latch, gate, busy, done, overflow, gate_sel_q});
            end
        end
        start = 1'b0;
        reset = 1'b1;
        half = 0;
        repeat (3) begin
            tick(1);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_busy: got %b required 0", busy);
            end
        end
    endtask

    task automatic test_single();
        int c0 = clr_cnt;
        int l0 = latch_cnt;
        res_t r;
        exp_t e;
        gate_sel = 2'd0;
        half = 2;
        push_exp(0, 2, 3, 1'b0);
        start_pulse();
        wait_for(0, 100, "single_done");
        if (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r.len !== e.len || r.pulses < e.pmin || r.pulses > e.pmax ||
                r.ovf !== e.ovf || r.selq !== e.selq) begin
                errors++;
                $display("FAIL single_result: got len=%0d pulses=%0d ovf=%b selq=%0d required len=%0d pulses=%0d..%0d ovf=%b selq=%0d",
                         r.len, r.pulses, r.ovf, r.selq, e.len, e.pmin, e.pmax, e.ovf, e.selq);
            end
        end
        checks++;
        if (clr_cnt - c0 !== 1 || latch_cnt - l0 !== 1) begin
            errors++;
            $display("FAIL single_strobes: got clr=%0d latch=%0d required 1 and 1",
                     clr_cnt - c0, latch_cnt - l0);
        end
        tick(HC);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_busy: got %b required 1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_end_idle: got %b required 0", busy);
        end
    endtask

    task automatic test_min_period();
        res_t r;
        exp_t e;
        gate_sel = 2'd0;
        half = 1;
        tick(3);
        push_exp(0, 5, 5, 1'b0);
        start_pulse();
        wait_for(0, 100, "minper_done");
        if (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r.len !== e.len || r.pulses < e.pmin || r.pulses > e.pmax ||
                r.ovf !== e.ovf || r.selq !== e.selq) begin
                errors++;
                $display("FAIL minper_result: got len=%0d pulses=%0d ovf=%b selq=%0d required len=%0d pulses=%0d ovf=%b selq=%0d",
                         r.len, r.pulses, r.ovf, r.selq, e.len, e.pmin, e.ovf, e.selq);
            end
        end
        tick(HC + 2);
    endtask

    task automatic test_range();
        res_t r;
        exp_t e;
        gate_sel = 2'd2;
        half = 2;
        push_exp(2, 250, 250, 1'b0);
        start_pulse();
        tick(100);
        gate_sel = 2'd0;
        wait_for(0, 2000, "range_done");
        if (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r.len !== e.len || r.pulses < e.pmin || r.pulses > e.pmax ||
                r.ovf !== e.ovf || r.selq !== e.selq) begin
                errors++;
                $display("FAIL range_result: got len=%0d pulses=%0d ovf=%b selq=%0d required len=%0d pulses=%0d ovf=%b selq=%0d",
                         r.len, r.pulses, r.ovf, r.selq, e.len, e.pmin, e.ovf, e.selq);
            end
        end
        half = 0;
        tick(HC + 2);
    endtask

    task automatic test_overflow();
        res_t r;
        exp_t e;
        gate_sel = 2'd0;
        // carry pulse mid-gate
        push_exp(0, 0, 0, 1'b1);
        start_pulse();
        wait_for(1, 20, "ovf_gate_wait");
        tick(3);
        carry_in = 1'b1;
        tick(1);
        carry_in = 1'b0;
        wait_for(0, 100, "ovf_gate_done");
        if (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r.len !== e.len || r.pulses !== e.pmin || r.ovf !== e.ovf || r.selq !== e.selq) begin
                errors++;
                $display("FAIL ovf_gate_result: got len=%0d ovf=%b selq=%0d required len=%0d ovf=%b selq=%0d",
                         r.len, r.ovf, r.selq, e.len, e.ovf, e.selq);
            end
        end
        tick(HC + 2);
        // no carry: overflow cleared by CLEAR
        push_exp(0, 0, 0, 1'b0);
        start_pulse();
        wait_for(3, 20, "ovf_clr_wait");
        tick(1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared: got %b required 0", overflow);
        end
        wait_for(0, 100, "ovf_none_done");
        if (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r.len !== e.len || r.ovf !== e.ovf || r.selq !== e.selq) begin
                errors++;
                $display("FAIL ovf_none_result: got len=%0d ovf=%b required len=%0d ovf=%b",
                         r.len, r.ovf, e.len, e.ovf);
            end
        end
        tick(HC + 2);
        // carry only during the latch cycle
        push_exp(0, 0, 0, 1'b1);
        start_pulse();
        wait_for(2, 40, "ovf_latch_wait");
        carry_in = 1'b1;
        tick(1);
        carry_in = 1'b0;
        wait_for(0, 10, "ovf_latch_done");
        if (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r.len !== e.len || r.ovf !== e.ovf || r.selq !== e.selq) begin
                errors++;
                $display("FAIL ovf_latch_result: got len=%0d ovf=%b required len=%0d ovf=%b",
                         r.len, r.ovf, e.len, e.ovf);
            end
        end
        tick(HC + 2);
    endtask

    task automatic test_continuous();
        int c0 = clr_cnt;
        int c1;
        res_t r;
        exp_t e;
        gate_sel = 2'd0;
        half = 0;
        cont = 1'b1;
        start_pulse();
        for (int m = 0; m < 3; m++) begin
            push_exp(0, 0, 0, 1'b0);
            if (m > 0) begin
                wait_for(1, 40, "cont_gate_wait");
                tick(2);
                if (m == 1) start_pulse();
                else cont = 1'b0;
            end
            wait_for(0, 60, "cont_done");
            if (res_q.size() > 0 && exp_q.size() > 0) begin
                r = res_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r.len !== e.len || r.ovf !== e.ovf || r.selq !== e.selq) begin
                    errors++;
                    $display("FAIL cont_result%0d: got len=%0d ovf=%b required len=%0d ovf=%b",
                             m, r.len, r.ovf, e.len, e.ovf);
                end
            end
            checks++;
            if (m == 0 && clr_cnt - c0 !== 1) begin
                errors++;
                $display("FAIL cont_single_clear: got %0d clears required 1", clr_cnt - c0);
            end else if (m > 0 && clr_period !== GB + HC + 3) begin
                errors++;
                $display("FAIL cont_period%0d: got %0d required %0d", m, clr_period, GB + HC + 3);
            end
        end
        tick(HC + 1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop_idle: got busy=%b required 0", busy);
        end
        c1 = clr_cnt;
        tick(40);
        checks++;
        if (clr_cnt !== c1) begin
            errors++;
            $display("FAIL cont_stop_noclr: got %0d extra clears required 0", clr_cnt - c1);
        end
    endtask

    task automatic test_abort();
        int l0;
        int d0;
        gate_sel = 2'd1;
        start_pulse();
        wait_for(1, 20, "abort_gate_wait");
        tick(5);
        l0 = latch_cnt;
        d0 = done_cnt;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        checks++;
        if ({gate, busy, overflow, gate_sel_q} !== 5'b0) begin
            errors++;
            $display("FAIL abort_state: got gate=%b busy=%b ovf=%b selq=%0d required all 0",
                     gate, busy, overflow, gate_sel_q);
        end
        tick(150);
        checks++;
        if (latch_cnt !== l0 || done_cnt !== d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got latch+%0d done+%0d busy=%b required 0 0 0",
                     latch_cnt - l0, done_cnt - d0, busy);
        end
        gate_sel = 2'd0;
    endtask

`ifdef FREQ_AUTORANGE_EN
    task automatic test_autorange();
        int sel_seq[5] = '{3, 2, 1, 0, 0};
        res_t r;
        exp_t e;
        half = 0;
        gate_sel = 2'd3;
        carry_in = 1'b1;
        cont = 1'b1;
        for (int m = 0; m < 5; m++) begin
            push_exp(sel_seq[m], 0, 0, 1'b1);
            if (m == 4) begin
                wait_for(1, 40, "auto_gate_wait");
                tick(2);
                cont = 1'b0;
            end
            wait_for(0, 12000, "auto_done");
            if (res_q.size() > 0 && exp_q.size() > 0) begin
                r = res_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r.len !== e.len || r.ovf !== e.ovf || r.selq !== e.selq) begin
                    errors++;
                    $display("FAIL auto_step%0d: got len=%0d ovf=%b selq=%0d required len=%0d ovf=%b selq=%0d",
                             m, r.len, r.ovf, r.selq, e.len, e.ovf, e.selq);
                end
            end
        end
        carry_in = 1'b0;
        tick(HC + 2);
        gate_sel = 2'd1;
        push_exp(1, 0, 0, 1'b0);
        start_pulse();
        wait_for(0, 200, "auto_reenter_done");
        if (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (r.len !== e.len || r.selq !== e.selq) begin
                errors++;
                $display("FAIL auto_reenter: got len=%0d selq=%0d required len=%0d selq=%0d",
                         r.len, r.selq, e.len, e.selq);
            end
        end
        tick(HC + 2);
    endtask
`endif

    task automatic test_exclusive();
        checks++;
        if (excl !== 0) begin
            errors++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles required 0", excl);
        end
        checks++;
        if (res_q.size() !== 0) begin
            errors++;
            $display("FAIL unexpected_done: got %0d unclaimed results required 0", res_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_min_period();
        test_range();
        test_overflow();
        test_continuous();
        test_abort();
`ifdef FREQ_AUTORANGE_EN
        test_autorange();
`endif
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
